pipe_mux_n: RTL

Parametrised N-input, WIDTH-bit multiplexer with a single registered output stage and valid/ready handshakes on every input and on the output. It replaces the combinational 2:1 word mux in the pipeline datapath wherever several producers feed one pipeline stage. It operates in one of two modes:
- **external select**: the `sel` port chooses the input.
- **round-robin**: an internal arbiter chooses among the valid inputs.

---
 rtl/pipe_mux_pkg.sv | 14 +
 rtl/pipe_mux_n_rr_arbiter.sv | 33 +++
 rtl/pipe_mux_n.sv | 79 +++++++
 3 files changed

// File: rtl/pipe_mux_pkg.sv
// Shared definitions for the pipelined N-input multiplexer.
package pipe_mux_pkg;

  localparam int ARB_EXT = 0;
  localparam int ARB_RR  = 1;

  // Select-field width for n channels; never narrower than one bit.
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pipe_mux_n_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr, cyclically.
module rr_arbiter
  import pipe_mux_pkg::*;
#(
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              grant_any
);

  int unsigned          idx;
  logic [SEL_W-1:0]     cand;

  // Scan ptr+1 .. ptr+NUM_IN modulo NUM_IN; the first hit wins.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      idx  = (32'(ptr) + k) % NUM_IN;
      cand = SEL_W'(idx);
      if (!grant_any && req[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

endmodule

// File: rtl/pipe_mux_n.sv
// N-input valid/ready multiplexer with one registered output stage.
module pipe_mux_n
  import pipe_mux_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int NUM_IN   = 4,
  parameter  int ARB_MODE = ARB_EXT,
  localparam int SEL_W    = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
);

  logic              stage_ready;
  logic [SEL_W-1:0]  chosen;
  logic              chosen_ok;
  logic              take;
  logic [WIDTH-1:0]  next_data;

  assign stage_ready = !out_valid || out_ready;

  generate
    if (ARB_MODE == ARB_RR) begin : g_rr
      logic [SEL_W-1:0] rr_ptr;

      rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .grant_idx (chosen),
        .grant_any (chosen_ok)
      );

      // Pointer moves only on an accepted word, so a stall never skips a channel.
      always_ff @(posedge clk or posedge reset) begin
        if (reset)     rr_ptr <= SEL_W'(NUM_IN - 1);
        else if (take) rr_ptr <= chosen;
      end
    end else begin : g_ext
      assign chosen    = sel;
      assign chosen_ok = (32'(sel) < NUM_IN);
    end
  endgenerate

  // Ready goes only to the chosen channel, and never while in reset.
  always_comb begin
    in_ready  = '0;
    next_data = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      in_ready[i] = !reset && stage_ready && chosen_ok && (chosen == SEL_W'(i));
      if (in_ready[i]) next_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign take = |(in_valid & in_ready);

  // Output register: load on accept, drop valid when consumed, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= next_data;
      out_src   <= chosen;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
